npc_predictor: RTL and testbench
================================

NPC_PREDICTOR -- requirements
Module: npc_predictor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter BTB_DEPTH, default 16, meaning BTB entries (power of 2, at least 2); IDX_W = log2(BTB_DEPTH).
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-004 The block SHALL have ports CPU_CLK (in, 1, clock) and CPU_RST_N (in, 1, asynchronous active-low reset).
REQ-005 The block SHALL have port PCF (in, ADDR_W), the fetch-stage PC.
REQ-006 The block SHALL have port PCE (in, ADDR_W), the execute-stage PC.
REQ-007 The block SHALL have ports BranchTarget, JalrTarget and JalTarget (in, ADDR_W each), the resolved targets.
REQ-008 The block SHALL have ports BrInstE (in, 1, valid conditional branch in EX), BranchE (in, 1, branch actually taken), PredTakenE (in, 1, prediction carried with the EX instruction), JalrE (in, 1) and JalD (in, 1).
REQ-009 The block SHALL have port PC_In (out, ADDR_W), the next PC.
REQ-010 The block SHALL have port PredTakenF (out, 1), the prediction for PCF.
REQ-011 The block SHALL have port MispredE (out, 1), the EX branch misprediction flag.
REQ-012 The block SHALL have ports BrCount and MispredCount (out, CNT_W each), the performance counters.

Function
REQ-013 Index SHALL be PC[IDX_W+1:2] and tag SHALL be PC[ADDR_W-1:IDX_W+2].
REQ-014 Each BTB entry SHALL hold a valid bit, a tag, an ADDR_W-bit target and a 2-bit saturating counter.
REQ-015 Lookup SHALL be combinational: hit = valid and tag match at PCF's index; PredTakenF = hit and counter[1].
REQ-016 MispredE SHALL equal BrInstE and (BranchE xor PredTakenE), combinationally.
REQ-017 PC_In priority: MispredE selects (BranchE ? BranchTarget : PCE+4).
REQ-018 PC_In priority, next: else JalrE selects JalrTarget.
REQ-019 PC_In priority, next: else JalD selects JalTarget.
REQ-020 PC_In priority, next: else PredTakenF selects the BTB target.
REQ-021 PC_In priority, last: else PC_In SHALL be PCF+4.
REQ-022 All PC additions SHALL be modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 SHALL not be flagged.
REQ-023 A correctly predicted branch (BrInstE, MispredE=0) SHALL NOT redirect, even when BranchE=1.
REQ-024 Updates SHALL occur on CPU_CLK rising edge only when BrInstE=1, at PCE's index.
REQ-025 On an update that hits with BranchE=1, the counter SHALL increment, saturating at 3, and the target SHALL be written with BranchTarget.
REQ-026 On an update that hits with BranchE=0, the counter SHALL decrement, saturating at 0; the target SHALL be unchanged.
REQ-027 On an update that misses with BranchE=1, the entry SHALL be allocated: valid=1, new tag, target=BranchTarget, counter=2, replacing any prior occupant.
REQ-028 On an update that misses with BranchE=0, the entry SHALL be unchanged.
REQ-029 When a same-cycle lookup and update hit the same index, the lookup SHALL see the pre-update contents; the new contents SHALL be visible the next cycle.
REQ-030 BrCount SHALL increment by 1 per cycle with BrInstE=1.
REQ-031 MispredCount SHALL increment by 1 per cycle with MispredE=1.
REQ-032 Both counters SHALL wrap from 2^CNT_W-1 to 0.
REQ-033 Stalls and flushes SHALL be applied by qualifying BrInstE upstream; the block SHALL have no stall input.

Reset
REQ-034 CPU_RST_N low SHALL immediately, without waiting for a clock edge, clear all valid bits, set all counters to 1, and zero BrCount and MispredCount.
REQ-035 During reset, the combinational outputs SHALL follow their inputs: PredTakenF=0 and PC_In=PCF+4 when no redirect input is active.
REQ-036 Reset asserted mid-update SHALL discard that update; targets and tags need no reset.
REQ-037 The first rising edge after CPU_RST_N rises SHALL perform normal updates.

Verification
REQ-038 Cold lookup: after reset, PCF=0x100 -> PredTakenF=0, PC_In=0x104.
REQ-039 Allocate then predict: BrInstE=1, BranchE=1, PredTakenE=0, PCE=0x100, BranchTarget=0x200 -> that cycle MispredE=1 and PC_In=0x200; next cycle PCF=0x100 -> PredTakenF=1 and PC_In=0x200; MispredCount=1 and BrCount=1.
REQ-040 Hysteresis: from counter=2, one not-taken update -> counter=1 and PredTakenF=0; two taken updates -> counter=3; one not-taken -> PredTakenF remains 1.
REQ-041 Priority: MispredE=1 with BranchE=0, PCE=0x300, and JalD=1 with JalTarget=0x500 in the same cycle -> PC_In=0x304; JalrE=1 with JalD=1 -> PC_In=JalrTarget.
REQ-042 Aliasing and wrap: BTB_DEPTH=16, branches at 0x100 and 0x140 (same index, different tags) -> the second allocation evicts the first, and a lookup of 0x100 misses; PCF=0xFFFFFFFC with no hit -> PC_In=0x0.
REQ-043 Async reset and counter wrap: CPU_RST_N pulsed low between clock edges with entries valid -> PredTakenF=0 immediately and counters read 0; with CNT_W=4, 17 branch cycles -> BrCount=1.

Source files
------------

// File: rtl/npc_predictor_if.sv
// Bundle between the fetch/execute pipeline and the next-PC predictor.
// The pipeline side is the master; the predictor is the slave.
interface npc_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] PCF;
    logic [ADDR_W-1:0] PCE;
    logic [ADDR_W-1:0] BranchTarget;
    logic [ADDR_W-1:0] JalrTarget;
    logic [ADDR_W-1:0] JalTarget;
    logic              BrInstE;
    logic              BranchE;
    logic              PredTakenE;
    logic              JalrE;
    logic              JalD;
    logic [ADDR_W-1:0] PC_In;
    logic              PredTakenF;
    logic              MispredE;
    logic [CNT_W-1:0]  BrCount;
    logic [CNT_W-1:0]  MispredCount;

    modport master (
        output PCF, PCE, BranchTarget, JalrTarget, JalTarget,
        output BrInstE, BranchE, PredTakenE, JalrE, JalD,
        input  PC_In, PredTakenF, MispredE, BrCount, MispredCount
    );

    modport slave (
        input  PCF, PCE, BranchTarget, JalrTarget, JalTarget,
        input  BrInstE, BranchE, PredTakenE, JalrE, JalD,
        output PC_In, PredTakenF, MispredE, BrCount, MispredCount
    );
endinterface

// File: rtl/npc_predictor.sv
// Next-PC selection with a direct-mapped BTB of 2-bit saturating counters,
// plus branch and misprediction performance counters.
module npc_predictor #(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input logic           CPU_CLK,
    input logic           CPU_RST_N,
    npc_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [BTB_DEPTH-1:0] valid;
    logic [TAG_W-1:0]     tags    [BTB_DEPTH];
    logic [ADDR_W-1:0]    targets [BTB_DEPTH];
    logic [1:0]           cnt     [BTB_DEPTH];

    logic [CNT_W-1:0]  brCount;
    logic [CNT_W-1:0]  mispredCount;
    logic [IDX_W-1:0]  fetchIdx;
    logic [IDX_W-1:0]  updIdx;
    logic [TAG_W-1:0]  fetchTag;
    logic [TAG_W-1:0]  updTag;
    logic              fetchHit;
    logic              updHit;
    logic              predTaken;
    logic              mispred;
    logic [ADDR_W-1:0] pcIn;
    logic              unusedPcBits;

    assign fetchIdx = bus.PCF[IDX_W+1:2];
    assign fetchTag = bus.PCF[ADDR_W-1:IDX_W+2];
    assign updIdx   = bus.PCE[IDX_W+1:2];
    assign updTag   = bus.PCE[ADDR_W-1:IDX_W+2];
    assign unusedPcBits = ^{bus.PCF[1:0], bus.PCE[1:0]};

    assign fetchHit  = valid[fetchIdx] && (tags[fetchIdx] == fetchTag);
    assign updHit    = valid[updIdx] && (tags[updIdx] == updTag);
    assign predTaken = fetchHit && cnt[fetchIdx][1];
    assign mispred   = bus.BrInstE && (bus.BranchE ^ bus.PredTakenE);

    // Redirect priority: EX misprediction, then JALR, then JAL, then BTB, else sequential.
    always_comb begin
        pcIn = bus.PCF + ADDR_W'(4);
        if (mispred) begin
            pcIn = bus.BranchE ? bus.BranchTarget : (bus.PCE + ADDR_W'(4));
        end else if (bus.JalrE) begin
            pcIn = bus.JalrTarget;
        end else if (bus.JalD) begin
            pcIn = bus.JalTarget;
        end else if (predTaken) begin
            pcIn = targets[fetchIdx];
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            valid        <= '0;
            brCount      <= '0;
            mispredCount <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                cnt[i] <= 2'd1;
            end
        end else begin
            if (bus.BrInstE) begin
                brCount <= brCount + CNT_W'(1);
                if (updHit) begin
                    if (bus.BranchE) begin
                        cnt[updIdx] <= (cnt[updIdx] == 2'd3) ? 2'd3 : cnt[updIdx] + 2'd1;
                    end else begin
                        cnt[updIdx] <= (cnt[updIdx] == 2'd0) ? 2'd0 : cnt[updIdx] - 2'd1;
                    end
                end else if (bus.BranchE) begin
                    valid[updIdx] <= 1'b1;
                    cnt[updIdx]   <= 2'd2;
                end
            end
            if (mispred) begin
                mispredCount <= mispredCount + CNT_W'(1);
            end
        end
    end

    // A taken update either refreshes a hit or allocates a miss; both rewrite tag and target.
    always_ff @(posedge CPU_CLK) begin
        if (bus.BrInstE && bus.BranchE) begin
            tags[updIdx]    <= updTag;
            targets[updIdx] <= bus.BranchTarget;
        end
    end

    assign bus.PC_In        = pcIn;
    assign bus.PredTakenF   = predTaken;
    assign bus.MispredE     = mispred;
    assign bus.BrCount      = brCount;
    assign bus.MispredCount = mispredCount;
endmodule

// File: tb/tb_npc_predictor.sv
// Scoreboard bench for npc_predictor: a reference BTB model plus directed
// expectations feed a queue that is drained against the DUT each cycle.
module tb_npc_predictor;
    localparam int ADDR_W    = 32;
    localparam int BTB_DEPTH = 16;
    localparam int CNT_W     = 4;

    typedef struct {
        logic [31:0] pcf, pce, brTgt, jalrTgt, jalTgt;
        logic        brInst, branch, predE, jalr, jal;
    } stim_t;

    typedef struct {
        string       tag;
        logic [31:0] pcIn;
        logic        predF;
        logic        misp;
    } exp_t;

    logic cpuClk = 1'b0;
    logic cpuRstN = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    logic        mValid  [BTB_DEPTH];
    logic [25:0] mTag    [BTB_DEPTH];
    logic [31:0] mTarget [BTB_DEPTH];
    logic [1:0]  mCnt    [BTB_DEPTH];
    logic [3:0]  mBrCount;
    logic [3:0]  mMispCount;

    always #5 cpuClk = ~cpuClk;

    npc_predictor_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    npc_predictor #(.ADDR_W(ADDR_W), .BTB_DEPTH(BTB_DEPTH), .CNT_W(CNT_W)) dut (
        .CPU_CLK  (cpuClk),
        .CPU_RST_N(cpuRstN),
        .bus      (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic stim_t idle(input logic [31:0] pc);
        stim_t s;
        s.pcf = pc; s.pce = 32'h0; s.brTgt = 32'h0; s.jalrTgt = 32'h0; s.jalTgt = 32'h0;
        s.brInst = 1'b0; s.branch = 1'b0; s.predE = 1'b0; s.jalr = 1'b0; s.jal = 1'b0;
        return s;
    endfunction

    function automatic stim_t branchOp(input logic [31:0] pcf, input logic [31:0] pce,
                                       input logic taken, input logic predE, input logic [31:0] tgt);
        stim_t s;
        s = idle(pcf);
        s.brInst = 1'b1; s.pce = pce; s.branch = taken; s.predE = predE; s.brTgt = tgt;
        return s;
    endfunction

    function automatic logic modelHit(input logic [31:0] pc);
        return mValid[pc[5:2]] && (mTag[pc[5:2]] == pc[31:6]);
    endfunction

    function automatic logic modelPred(input logic [31:0] pc);
        return modelHit(pc) && mCnt[pc[5:2]][1];
    endfunction

    function automatic logic modelMisp(input stim_t s);
        return s.brInst && (s.branch != s.predE);
    endfunction

    function automatic logic [31:0] modelPcIn(input stim_t s);
        if (modelMisp(s)) return s.branch ? s.brTgt : s.pce + 32'd4;
        if (s.jalr) return s.jalrTgt;
        if (s.jal) return s.jalTgt;
        if (modelPred(s.pcf)) return mTarget[s.pcf[5:2]];
        return s.pcf + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < BTB_DEPTH; i++) begin
            mValid[i] = 1'b0;
            mCnt[i]   = 2'd1;
        end
        mBrCount   = 4'd0;
        mMispCount = 4'd0;
    endtask

    task automatic modelUpdate(input stim_t s);
        logic [3:0] i;
        i = s.pce[5:2];
        if (s.brInst) begin
            if (modelHit(s.pce)) begin
                if (s.branch) begin
                    if (mCnt[i] != 2'd3) mCnt[i] = mCnt[i] + 2'd1;
                    mTarget[i] = s.brTgt;
                end else if (mCnt[i] != 2'd0) begin
                    mCnt[i] = mCnt[i] - 2'd1;
                end
            end else if (s.branch) begin
                mValid[i]  = 1'b1;
                mTag[i]    = s.pce[31:6];
                mTarget[i] = s.brTgt;
                mCnt[i]    = 2'd2;
            end
            mBrCount = mBrCount + 4'd1;
        end
        if (modelMisp(s)) mMispCount = mMispCount + 4'd1;
    endtask

    task automatic driveBus(input stim_t s);
        bus.PCF = s.pcf; bus.PCE = s.pce; bus.BranchTarget = s.brTgt;
        bus.JalrTarget = s.jalrTgt; bus.JalTarget = s.jalTgt;
        bus.BrInstE = s.brInst; bus.BranchE = s.branch; bus.PredTakenE = s.predE;
        bus.JalrE = s.jalr; bus.JalD = s.jal;
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] pcIn, input logic predF, input logic misp);
        exp_t e;
        e.tag = tag; e.pcIn = pcIn; e.predF = predF; e.misp = misp;
        expQ.push_back(e);
    endtask

    task automatic drainQueue();
        exp_t e;
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, "/PC_In"}, bus.PC_In, e.pcIn);
            checkOutput({e.tag, "/PredTakenF"}, 32'(bus.PredTakenF), 32'(e.predF));
            checkOutput({e.tag, "/MispredE"}, 32'(bus.MispredE), 32'(e.misp));
        end
    endtask

    // One cycle: drive at negedge, compare combinational outputs, then counters after the edge.
    task automatic applyStimulus(input stim_t s);
        @(negedge cpuClk);
        driveBus(s);
        pushExpect("model", modelPcIn(s), modelPred(s.pcf), modelMisp(s));
        #2;
        drainQueue();
        @(posedge cpuClk);
        if (cpuRstN) modelUpdate(s);
        #1;
        checkOutput("BrCount", 32'(bus.BrCount), 32'(mBrCount));
        checkOutput("MispredCount", 32'(bus.MispredCount), 32'(mMispCount));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        logic [31:0] pcPool [6];
        pcPool[0] = 32'h100; pcPool[1] = 32'h140; pcPool[2] = 32'h180;
        pcPool[3] = 32'h1C4; pcPool[4] = 32'h204; pcPool[5] = 32'hFFFF_FFFC;

        driveBus(idle(32'h100));
        modelReset();
        #1 cpuRstN = 1'b0;
        #2;
        pushExpect("inReset", 32'h104, 1'b0, 1'b0);
        drainQueue();
        checkOutput("resetBrCount", 32'(bus.BrCount), 32'h0);
        checkOutput("resetMispCount", 32'(bus.MispredCount), 32'h0);
        repeat (2) @(posedge cpuClk);
        @(negedge cpuClk) cpuRstN = 1'b1;

        pushExpect("coldLookup", 32'h104, 1'b0, 1'b0);
        applyStimulus(idle(32'h100));

        pushExpect("allocate", 32'h200, 1'b0, 1'b1);
        applyStimulus(branchOp(32'h104, 32'h100, 1'b1, 1'b0, 32'h200));
        checkOutput("allocBrCount", 32'(bus.BrCount), 32'h1);
        checkOutput("allocMispCount", 32'(bus.MispredCount), 32'h1);
        pushExpect("predictAfterAlloc", 32'h200, 1'b1, 1'b0);
        applyStimulus(idle(32'h100));

        pushExpect("sameCycleLookup", 32'h104, 1'b1, 1'b1);
        applyStimulus(branchOp(32'h100, 32'h100, 1'b0, 1'b1, 32'h0));
        pushExpect("weakNotTaken", 32'h104, 1'b0, 1'b0);
        applyStimulus(idle(32'h100));
        applyStimulus(branchOp(32'h500, 32'h100, 1'b1, 1'b0, 32'h200));
        applyStimulus(branchOp(32'h500, 32'h100, 1'b1, 1'b1, 32'h200));
        applyStimulus(branchOp(32'h500, 32'h100, 1'b0, 1'b1, 32'h0));
        pushExpect("hysteresis", 32'h200, 1'b1, 1'b0);
        applyStimulus(idle(32'h100));

        s = branchOp(32'h800, 32'h300, 1'b0, 1'b1, 32'h0);
        s.jal = 1'b1; s.jalTgt = 32'h500;
        pushExpect("mispredOverJal", 32'h304, 1'b0, 1'b1);
        applyStimulus(s);
        s = idle(32'h800);
        s.jal = 1'b1; s.jalTgt = 32'h500; s.jalr = 1'b1; s.jalrTgt = 32'h600;
        pushExpect("jalrOverJal", 32'h600, 1'b0, 1'b0);
        applyStimulus(s);
        pushExpect("correctTakenNoRedirect", 32'h404, 1'b0, 1'b0);
        applyStimulus(branchOp(32'h400, 32'h100, 1'b1, 1'b1, 32'h200));

        pushExpect("aliasAlloc", 32'h700, 1'b0, 1'b1);
        applyStimulus(branchOp(32'h104, 32'h140, 1'b1, 1'b0, 32'h700));
        pushExpect("aliasEvicted", 32'h104, 1'b0, 1'b0);
        applyStimulus(idle(32'h100));
        pushExpect("aliasNewHit", 32'h700, 1'b1, 1'b0);
        applyStimulus(idle(32'h140));
        pushExpect("fetchWrap", 32'h0, 1'b0, 1'b0);
        applyStimulus(idle(32'hFFFF_FFFC));
        pushExpect("pceWrap", 32'h0, 1'b0, 1'b1);
        applyStimulus(branchOp(32'h100, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0));

        for (int n = 0; n < 60; n++) begin
            s = branchOp(pcPool[$urandom_range(0, 5)], pcPool[$urandom_range(0, 5)],
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom() & 32'hFFFF_FFFC);
            s.brInst  = 1'($urandom_range(0, 3) != 0);
            s.jalr    = ($urandom_range(0, 7) == 0);
            s.jal     = ($urandom_range(0, 7) == 0);
            s.jalrTgt = $urandom() & 32'hFFFF_FFFC;
            s.jalTgt  = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(s);
        end

        applyStimulus(branchOp(32'h104, 32'h140, 1'b1, 1'b0, 32'h700));
        applyStimulus(branchOp(32'h104, 32'h140, 1'b1, 1'b0, 32'h700));
        pushExpect("beforeAsyncReset", 32'h700, 1'b1, 1'b0);
        applyStimulus(idle(32'h140));

        #2 cpuRstN = 1'b0;
        #1;
        modelReset();
        pushExpect("asyncReset", 32'h144, 1'b0, 1'b0);
        drainQueue();
        checkOutput("asyncBrCount", 32'(bus.BrCount), 32'h0);
        checkOutput("asyncMispCount", 32'(bus.MispredCount), 32'h0);
        @(negedge cpuClk);
        driveBus(branchOp(32'h104, 32'h180, 1'b1, 1'b0, 32'h900));
        @(posedge cpuClk);
        @(negedge cpuClk);
        driveBus(idle(32'h180));
        cpuRstN = 1'b1;

        pushExpect("discardedUpdate", 32'h184, 1'b0, 1'b0);
        applyStimulus(idle(32'h180));
        for (int n = 0; n < 17; n++) begin
            applyStimulus(branchOp(32'h104, 32'h900, 1'b0, 1'b0, 32'h0));
        end
        checkOutput("brCountWrap", 32'(bus.BrCount), 32'h1);
        checkOutput("mispCountAfterWrap", 32'(bus.MispredCount), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
